axi4_burst_slave_mem: RTL

- AXI4 (full) memory slave: the responder end of the burst-master protocol driven by the team's AXI master IPs.
- Replaces the VIP slave in example designs, so master burst tests run against synthesizable RTL.
- Accepts INCR/FIXED write and read bursts into an internal word-addressed RAM.
- Services one transaction at a time, with fair write/read arbitration.

---
 rtl/axi4_burst_slave_mem.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst memory slave: services one INCR/FIXED write or read burst at a time
// against an internal word-addressed RAM, with round-robin AW/AR arbitration.
module axi4_burst_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                              S00_AXI_ACLK,
    input  logic                              S00_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S00_AXI_AWADDR,
    input  logic [7:0]                        S00_AXI_AWLEN,
    input  logic [1:0]                        S00_AXI_AWBURST,
    input  logic                              S00_AXI_AWVALID,
    output logic                              S00_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S00_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S00_AXI_WSTRB,
    input  logic                              S00_AXI_WLAST,
    input  logic                              S00_AXI_WVALID,
    output logic                              S00_AXI_WREADY,
    output logic [1:0]                        S00_AXI_BRESP,
    output logic                              S00_AXI_BVALID,
    input  logic                              S00_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S00_AXI_ARADDR,
    input  logic [7:0]                        S00_AXI_ARLEN,
    input  logic [1:0]                        S00_AXI_ARBURST,
    input  logic                              S00_AXI_ARVALID,
    output logic                              S00_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S00_AXI_RDATA,
    output logic [1:0]                        S00_AXI_RRESP,
    output logic                              S00_AXI_RLAST,
    output logic                              S00_AXI_RVALID,
    input  logic                              S00_AXI_RREADY
);
    localparam int BYTES  = C_S_AXI_DATA_WIDTH / 8;
    localparam int LSB    = $clog2(BYTES);
    localparam int WORD_W = C_S_AXI_ADDR_WIDTH - LSB;
    localparam int DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2,
        R_DATA = 2'd3
    } state_t;

    state_t                          state_r, state_next_s;
    logic [WORD_W-1:0]               addr_r, rd_addr_s;
    logic [7:0]                      len_r, cnt_r;
    logic [1:0]                      burst_r;
    logic                            err_r, last_wr_r;
    logic [C_S_AXI_DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [C_S_AXI_DATA_WIDTH-1:0]   ram_q_r, rdata_r;
    logic [1:0]                      rresp_r;
    logic                            rlast_r, rvalid_r;
    logic                            grant_wr_s, grant_rd_s;
    logic                            awready_s, arready_s, wready_s, bvalid_s;
    logic [1:0]                      bresp_s;
    logic                            w_hs_s, r_load_s, r_done_s;
    logic                            unsupported_s, final_beat_s;
    logic                            unused_s;

    function automatic logic [WORD_W-1:0] next_addr(input logic [WORD_W-1:0] a,
                                                    input logic [1:0] burst);
        if (burst == 2'b01) begin
            next_addr = a + {{(WORD_W-1){1'b0}}, 1'b1};
        end else begin
            next_addr = a;
        end
    endfunction

    // Low address bits select bytes within a word and are deliberately ignored.
    assign unused_s = ^{S00_AXI_AWADDR[LSB-1:0], S00_AXI_ARADDR[LSB-1:0]};

    assign grant_wr_s    = S00_AXI_AWVALID & (~S00_AXI_ARVALID | ~last_wr_r);
    assign grant_rd_s    = S00_AXI_ARVALID & (~S00_AXI_AWVALID | last_wr_r);
    assign unsupported_s = burst_r[1];
    assign final_beat_s  = (cnt_r == len_r);
    assign w_hs_s        = wready_s & S00_AXI_WVALID;
    assign r_done_s      = rvalid_r & rlast_r & S00_AXI_RREADY;
    assign r_load_s      = (state_r == R_DATA) & ~(rvalid_r & rlast_r) & (~rvalid_r | S00_AXI_RREADY);

    // State register.
    always_ff @(posedge S00_AXI_ACLK) begin
        if (!S00_AXI_ARESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (awready_s) begin
                    state_next_s = W_DATA;
                end else if (arready_s) begin
                    state_next_s = R_DATA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s && final_beat_s) begin
                    state_next_s = W_RESP;
                end else begin
                    state_next_s = W_DATA;
                end
            end
            W_RESP: begin
                if (S00_AXI_BREADY) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = W_RESP;
                end
            end
            R_DATA: begin
                if (r_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = R_DATA;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Channel handshake outputs; address readies are masked while reset is applied.
    always_comb begin
        awready_s = 1'b0;
        arready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        bresp_s   = 2'b00;
        case (state_r)
            IDLE: begin
                awready_s = S00_AXI_ARESETN & grant_wr_s;
                arready_s = S00_AXI_ARESETN & grant_rd_s;
            end
            W_DATA: wready_s = 1'b1;
            W_RESP: begin
                bvalid_s = 1'b1;
                bresp_s  = (err_r | unsupported_s) ? 2'b10 : 2'b00;
            end
            R_DATA: wready_s = 1'b0;
            default: wready_s = 1'b0;
        endcase
    end

    // Read address: AR address in IDLE, otherwise the beat after the one being loaded.
    always_comb begin
        rd_addr_s = addr_r;
        if (state_r == IDLE) begin
            rd_addr_s = S00_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
        end else if (r_load_s) begin
            rd_addr_s = next_addr(addr_r, burst_r);
        end else begin
            rd_addr_s = addr_r;
        end
    end

    // Burst bookkeeping and the registered R channel.
    always_ff @(posedge S00_AXI_ACLK) begin
        if (!S00_AXI_ARESETN) begin
            addr_r    <= {WORD_W{1'b0}};
            len_r     <= 8'd0;
            burst_r   <= 2'b00;
            cnt_r     <= 8'd0;
            err_r     <= 1'b0;
            last_wr_r <= 1'b0;
            rdata_r   <= {C_S_AXI_DATA_WIDTH{1'b0}};
            rresp_r   <= 2'b00;
            rlast_r   <= 1'b0;
            rvalid_r  <= 1'b0;
        end else begin
            if (awready_s) begin
                addr_r    <= S00_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
                len_r     <= S00_AXI_AWLEN;
                burst_r   <= S00_AXI_AWBURST;
                cnt_r     <= 8'd0;
                err_r     <= 1'b0;
                last_wr_r <= 1'b1;
            end else if (arready_s) begin
                addr_r    <= S00_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
                len_r     <= S00_AXI_ARLEN;
                burst_r   <= S00_AXI_ARBURST;
                cnt_r     <= 8'd0;
                last_wr_r <= 1'b0;
            end else if (w_hs_s) begin
                if (S00_AXI_WLAST != final_beat_s) begin
                    err_r <= 1'b1;
                end
                if (!final_beat_s) begin
                    cnt_r  <= cnt_r + 8'd1;
                    addr_r <= next_addr(addr_r, burst_r);
                end
            end else if (r_load_s) begin
                addr_r <= rd_addr_s;
                if (!final_beat_s) begin
                    cnt_r <= cnt_r + 8'd1;
                end
            end

            if (r_load_s) begin
                rdata_r  <= unsupported_s ? {C_S_AXI_DATA_WIDTH{1'b0}} : ram_q_r;
                rresp_r  <= unsupported_s ? 2'b10 : 2'b00;
                rlast_r  <= final_beat_s;
                rvalid_r <= 1'b1;
            end else if (rvalid_r && S00_AXI_RREADY) begin
                rdata_r  <= {C_S_AXI_DATA_WIDTH{1'b0}};
                rresp_r  <= 2'b00;
                rlast_r  <= 1'b0;
                rvalid_r <= 1'b0;
            end
        end
    end

    // RAM: byte-strobed write port, synchronous read that is re-issued while stalled.
    always_ff @(posedge S00_AXI_ACLK) begin
        if (w_hs_s && !unsupported_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S00_AXI_WSTRB[b]) begin
                    mem_r[addr_r][8*b +: 8] <= S00_AXI_WDATA[8*b +: 8];
                end
            end
        end
        ram_q_r <= mem_r[rd_addr_s];
    end

    assign S00_AXI_AWREADY = awready_s;
    assign S00_AXI_ARREADY = arready_s;
    assign S00_AXI_WREADY  = wready_s;
    assign S00_AXI_BVALID  = bvalid_s;
    assign S00_AXI_BRESP   = bresp_s;
    assign S00_AXI_RDATA   = rdata_r;
    assign S00_AXI_RRESP   = rresp_r;
    assign S00_AXI_RLAST   = rlast_r;
    assign S00_AXI_RVALID  = rvalid_r;

endmodule
